// File: rtl/mem_stage_ctrl.sv
// Memory-stage access sequencer: decodes RV32I loads/stores, drives a req/ack data port and stalls
// the pipeline until the access completes. Optional watchdog enabled by MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misalign,
  output logic        timeout
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state;
  logic        supported, misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  ld_size_q, ld_off_q;
  logic        ld_unsigned_q;
  logic [31:0] lane, ld_ext;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q;
`endif

  always_comb begin
    supported  = ((opcode == OpLoad) && (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
              || ((opcode == OpStore) && (func3 inside {3'b000, 3'b001, 3'b010}));
    misaligned = ((func3[1:0] == 2'b01) && addr[0])
              || ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (func3[1:0])
      2'b00:   begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01:   begin
        be_d    = 4'b0011 << {addr[1], 1'b0};
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  // Loaded lane is shifted down to bit 0 before extension.
  always_comb begin
    lane = mem_rdata >> {ld_off_q, 3'b000};
    case (ld_size_q)
      2'b00:   ld_ext = {{24{~ld_unsigned_q & lane[7]}}, lane[7:0]};
      2'b01:   ld_ext = {{16{~ld_unsigned_q & lane[15]}}, lane[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Gated by reset so an in-flight access releases the pipeline immediately.
  assign stall = reset && (((state == StIdle) && supported && !misaligned) || (state == StAccess));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= StIdle;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      load_data     <= '0;
      load_valid    <= 1'b0;
      misalign      <= 1'b0;
      timeout       <= 1'b0;
      ld_size_q     <= '0;
      ld_off_q      <= '0;
      ld_unsigned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        StIdle: begin
          if (supported && !misaligned) begin
            state         <= StAccess;
            mem_req       <= 1'b1;
            mem_we        <= (opcode == OpStore);
            mem_addr      <= {addr[31:2], 2'b00};
            mem_be        <= be_d;
            mem_wdata     <= wdata_d;
            ld_size_q     <= func3[1:0];
            ld_off_q      <= addr[1:0];
            ld_unsigned_q <= func3[2];
`ifdef MEM_TIMEOUT_EN
            cnt_q         <= '0;
`endif
          end else if (supported) begin
            state    <= StErr;
            misalign <= 1'b1;
          end
        end
        StAccess: begin
          if (mem_ack) begin
            state   <= StDone;
            mem_req <= 1'b0;
            if (!mem_we) begin
              load_data  <= ld_ext;
              load_valid <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            state   <= StErr;
            mem_req <= 1'b0;
            timeout <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
`endif
        end
        StDone:  state <= StIdle;
        StErr:   state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: transaction-level reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_mem_stage_ctrl;

  localparam int unsigned TO = 15;
`ifdef MEM_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic mem_req, mem_we, load_valid, stall, misalign, timeout;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0] mem_be;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .addr(addr),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .load_data(load_data), .load_valid(load_valid), .stall(stall), .misalign(misalign),
    .timeout(timeout)
  );

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // 0 = not a memory op, 1 = performed, 2 = misaligned
  function automatic int kind(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    if (op == 7'h03) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    end else if (op == 7'h23) begin
      if (f3 > 3'd2) return 0;
    end else return 0;
    nb = 1 << f3[1:0];
    return (int'(a[1:0]) % nb == 0) ? 1 : 2;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    int base = int'(a[1:0]) - int'(a[1:0]) % nb;
    return 4'(((1 << nb) - 1) << base);
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ext_of(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * int'(off));
    if (f3[1:0] == 2'd0) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'd1) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  int m_phase = 0;  // 0 free, 1 request outstanding, 2 finished, 3 dropped
  int m_wait = 0;   // cycles the request has been visible
  logic [2:0] m_f3 = '0;
  logic [1:0] m_off = '0;
  logic m_load = 1'b0;
  logic exp_req = 0, exp_we = 0, exp_lv = 0, exp_mis = 0, exp_to = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_ld = '0;
  logic [3:0] exp_be = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_wait <= 0; exp_req <= 0; exp_we <= 0; exp_lv <= 0; exp_mis <= 0;
      exp_to <= 0; exp_addr <= '0; exp_wdata <= '0; exp_ld <= '0; exp_be <= '0;
    end else begin
      exp_lv <= 0; exp_mis <= 0; exp_to <= 0;
      case (m_phase)
        0: begin
          if (kind(opcode, func3, addr) == 1) begin
            m_phase <= 1; m_wait <= 1; exp_req <= 1;
            m_load <= (opcode == 7'h03); m_f3 <= func3; m_off <= addr[1:0];
            exp_we <= (opcode == 7'h23); exp_addr <= addr & 32'hFFFF_FFFC;
            exp_be <= be_of(func3, addr); exp_wdata <= wdata_of(func3, store_data);
          end else if (kind(opcode, func3, addr) == 2) begin
            m_phase <= 3; exp_mis <= 1;
          end
        end
        1: begin
          if (mem_ack) begin
            m_phase <= 2; exp_req <= 0;
            if (m_load) begin
              exp_ld <= ext_of(m_f3, m_off, mem_rdata); exp_lv <= 1;
            end
          end else if (ToEn && m_wait == int'(TO)) begin
            m_phase <= 3; exp_req <= 0; exp_to <= 1;
          end else m_wait <= m_wait + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("load_data", load_data, exp_ld);
      chk("load_valid", 32'(load_valid), 32'(exp_lv));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      chk("timeout", 32'(timeout), 32'(exp_to));
      chk("stall", 32'(stall), 32'(reset && ((m_phase == 0 && kind(opcode, func3, addr) == 1)
                                             || m_phase == 1)));
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int stall_c, req_c, lv_c, mis_c, to_c;
    logic [31:0] addr, wdata;
    logic [3:0] be;
    logic we, done;
  } res_t;

  // ack_after = n: ack sampled on the (n+1)th request cycle; negative = never
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int ack_after,
                        output res_t r);
    r = '{stall_c: 0, req_c: 0, lv_c: 0, mis_c: 0, to_c: 0, addr: '0, wdata: '0, be: '0,
          we: 1'b0, done: 1'b0};
    opcode = op; func3 = f3; addr = a; store_data = sd; mem_rdata = rd; mem_ack = 1'b0;
    #1;
    if (stall) r.stall_c++;
    for (int c = 0; c < 60 && !r.done; c++) begin
      @(negedge clk); #1;
      if (stall) r.stall_c++;
      if (load_valid) r.lv_c++;
      if (misalign) r.mis_c++;
      if (timeout) r.to_c++;
      if (mem_req) begin
        r.req_c++;
        r.addr = mem_addr; r.wdata = mem_wdata; r.be = mem_be; r.we = mem_we;
        mem_ack = (r.req_c == ack_after + 1);
      end else begin
        mem_ack = 1'b0;
        if (r.req_c > 0 || misalign || timeout || c >= 2) r.done = 1'b1;
      end
    end
    opcode = '0; func3 = '0; mem_ack = 1'b0;
    chk("op_completes", 32'(r.done), 32'd1);
    @(negedge clk); #1;
  endtask

  res_t r;

  initial begin
    reset = 1'b0;
    #23;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk); #1;

    run_op(7'h03, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, r);
    chk("lw_stall_cycles", r.stall_c, 2);
    chk("lw_req_cycles", r.req_c, 1);
    chk("lw_valid_cycles", r.lv_c, 1);
    chk("lw_be", 32'(r.be), 32'hF);
    chk("lw_data", load_data, 32'hDEAD_BEEF);

    run_op(7'h03, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 2, r);
    chk("lb_be", 32'(r.be), 32'h8);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", r.stall_c, 4);
    run_op(7'h03, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 1, r);
    chk("lbu_data", load_data, 32'h0000_0080);

    run_op(7'h23, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 1, r);
    chk("sh_we", 32'(r.we), 32'd1);
    chk("sh_be", 32'(r.be), 32'hC);
    chk("sh_wdata", r.wdata, 32'hABCD_ABCD);
    chk("sh_addr", r.addr, 32'h20);
    chk("sh_no_valid", r.lv_c, 0);
    chk("load_data_holds", load_data, 32'h0000_0080);

    run_op(7'h03, 3'b010, 32'h102, 32'h0, 32'h0, 0, r);
    chk("mis_pulse", r.mis_c, 1);
    chk("mis_no_req", r.req_c, 0);
    chk("mis_no_stall", r.stall_c, 0);

    // Further patterns, checked by the model only.
    run_op(7'h03, 3'b001, 32'h106, 32'h0, 32'h8001_7FFF, 0, r);
    run_op(7'h03, 3'b101, 32'h104, 32'h0, 32'h8001_7FFF, 3, r);
    chk("lhu_data", load_data, 32'h0000_7FFF);
    run_op(7'h23, 3'b000, 32'h1, 32'h1234_5678, 32'h0, 0, r);
    chk("sb_wdata", r.wdata, 32'h7878_7878);
    run_op(7'h23, 3'b010, 32'h44, 32'hCAFE_F00D, 32'h0, 2, r);
    run_op(7'h23, 3'b001, 32'h45, 32'h0, 32'h0, 0, r);
    run_op(7'h03, 3'b011, 32'h40, 32'h0, 32'h0, 0, r);
    chk("unsup_no_req", r.req_c, 0);
    run_op(7'h33, 3'b010, 32'h40, 32'h0, 32'h0, 0, r);

`ifdef MEM_TIMEOUT_EN
    run_op(7'h03, 3'b010, 32'h300, 32'h0, 32'h1111_2222, -1, r);
    chk("to_req_cycles", r.req_c, 15);
    chk("to_pulse", r.to_c, 1);
    chk("to_stall_cycles", r.stall_c, 16);
    run_op(7'h03, 3'b010, 32'h300, 32'h0, 32'h3333_4444, 14, r);
    chk("ack15_req_cycles", r.req_c, 15);
    chk("ack15_no_timeout", r.to_c, 0);
    chk("ack15_valid", r.lv_c, 1);
`else
    run_op(7'h03, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 24, r);
    chk("wait_req_cycles", r.req_c, 25);
    chk("wait_no_timeout", r.to_c, 0);
`endif

    // Ack while idle is ignored.
    mem_ack = 1'b1;
    @(negedge clk); #1;
    chk("idle_ack_ignored", 32'(load_valid), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk); #1;

    // Reset three cycles into an access.
    opcode = 7'h03; func3 = 3'b010; addr = 32'h200; mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 10 && !(mem_req && c == 3); c++) begin
      @(negedge clk); #1;
    end
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_drop_req", 32'(mem_req), 32'd0);
    chk("rst_drop_stall", 32'(stall), 32'd0);
    mem_ack = 1'b1;
    @(negedge clk); #1;
    opcode = '0;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("late_ack_no_valid", 32'(load_valid), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("late_ack_no_req", 32'(mem_req), 32'd0);
    chk("late_ack_data", load_data, 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
